// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures a PWM waveform on one asynchronous GPIO. For each period it builds a
//   record {sat, high_cnt, period_cnt} in clk cycles and queues it in a show-ahead
//   FIFO for the host.
//
//   Ports
//     clk        system clock
//     reset      asynchronous, active-high reset
//     pin        PWM input, asynchronous to clk
//     enable     1 = measure; 0 = idle, partial measurement discarded
//     pop        consume the head record (ignored while empty)
//     clr_ovf    clear the overflow sticky bit
//     rd_high    head record: high time in cycles
//     rd_period  head record: period in cycles
//     rd_sat     head record: a counter saturated during this record
//     empty      FIFO empty (rd_* are don't-care while empty)
//     full       FIFO full
//     overflow   sticky: a record was dropped because the FIFO was full
//     fsm_state  debug view of the measurement FSM (0 IDLE, 1 ARM, 2 HIGH, 3 LOW)
//
//   Read handshake: the head record is valid whenever empty=0 (valid = ~empty) and
//   pop acts as ready; a record transfers on every clock edge where ~empty & pop.
//   The FSM-to-FIFO push is a one-cycle strobe with no back-pressure: when the
//   FIFO cannot accept it, the record is dropped and overflow is set.
module pwm_capture #(
   parameter int CNT_W       = 24,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pin,
   input  logic             enable,
   input  logic             pop,
   input  logic             clr_ovf,
   output logic [CNT_W-1:0] rd_high,
   output logic [CNT_W-1:0] rd_period,
   output logic             rd_sat,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic [1:0]       fsm_state
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int REC_W = 2 * CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Pin synchronizer and edge detect
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_d;
   logic                   rise;
   logic                   fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         s_d    <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   // ------------------------------------------------------------------
   // Measurement FSM
   // ------------------------------------------------------------------
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] period_n;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] high_n;
   logic             period_max;
   logic             push;
   logic [REC_W-1:0] push_rec;

   // high_cnt never runs ahead of period_cnt, so period reaching all-ones is
   // the only saturation event that needs handling; it closes the record.
   assign period_max = (period_cnt == CNT_MAX);
   assign push_rec   = {period_max, high_cnt, period_cnt};
   assign fsm_state  = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         period_cnt <= '0;
         high_cnt   <= '0;
      end else begin
         state      <= state_n;
         period_cnt <= period_n;
         high_cnt   <= high_n;
      end
   end

   always_comb begin
      state_n  = state;
      period_n = period_cnt;
      high_n   = high_cnt;
      push     = 1'b0;
      if (!enable) begin
         state_n  = IDLE;
         period_n = '0;
         high_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n  = ARM;
               period_n = '0;
               high_n   = '0;
            end
            ARM: begin
               if (rise) begin
                  state_n  = HIGH;
                  period_n = CNT_ONE;
                  high_n   = CNT_ONE;
               end
            end
            HIGH: begin
               if (period_max) begin
                  // Stuck-high pin: emit one saturated record and re-arm.
                  push     = 1'b1;
                  state_n  = ARM;
                  period_n = '0;
                  high_n   = '0;
               end else begin
                  period_n = period_cnt + CNT_ONE;
                  if (fall) begin
                     state_n = LOW;
                  end else begin
                     high_n = high_cnt + CNT_ONE;
                  end
               end
            end
            LOW: begin
               if (period_max) begin
                  // Stuck-low pin: emit one saturated record and re-arm.
                  push     = 1'b1;
                  state_n  = ARM;
                  period_n = '0;
                  high_n   = '0;
               end else if (rise) begin
                  // Close this period and start the next one in the same cycle.
                  push     = 1'b1;
                  state_n  = HIGH;
                  period_n = CNT_ONE;
                  high_n   = CNT_ONE;
               end else begin
                  period_n = period_cnt + CNT_ONE;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Record FIFO (show-ahead, extra pointer bit distinguishes full/empty)
   // ------------------------------------------------------------------
   logic [REC_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;
   logic             drop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & ~do_push;

   assign {rd_sat, rd_high, rd_period} = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_rec;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         // A drop wins over a simultaneous clear.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Self-checking bench for pwm_capture. The pin is driven as a list of
//   (high, low) segments in whole clk cycles; every completed period of a
//   segment list is expected as the record {0, high, high+low}. A second
//   instance with 4-bit counters covers stuck-low and stuck-high saturation.
module tb_pwm_capture;

   localparam int CNT_W = 24;
   localparam int REC_W = 2 * CNT_W + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // main instance (24-bit counters)
   logic             pin, enable, pop, clr_ovf;
   logic [CNT_W-1:0] rd_high, rd_period;
   logic             rd_sat, empty, full, overflow;
   logic [1:0]       fsm_state;

   // small instance (4-bit counters) for saturation
   logic             pin_s, enable_s, pop_s, clr_ovf_s;
   logic [3:0]       rd_high_s, rd_period_s;
   logic             rd_sat_s, empty_s, full_s, overflow_s;
   logic [1:0]       fsm_state_s;

   pwm_capture #(.CNT_W(CNT_W), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .pin(pin), .enable(enable), .pop(pop),
      .clr_ovf(clr_ovf), .rd_high(rd_high), .rd_period(rd_period),
      .rd_sat(rd_sat), .empty(empty), .full(full), .overflow(overflow),
      .fsm_state(fsm_state)
   );

   pwm_capture #(.CNT_W(4), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut_s (
      .clk(clk), .reset(reset), .pin(pin_s), .enable(enable_s), .pop(pop_s),
      .clr_ovf(clr_ovf_s), .rd_high(rd_high_s), .rd_period(rd_period_s),
      .rd_sat(rd_sat_s), .empty(empty_s), .full(full_s), .overflow(overflow_s),
      .fsm_state(fsm_state_s)
   );

   // ---------------- scoreboard ----------------
   int               tests = 0;
   int               fails = 0;
   logic [REC_W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // All driving happens 1 time unit after a rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold_pin(input logic v, input int n);
      pin = v;
      step(n);
   endtask

   // One high/low segment; it becomes a record once the next rise arrives.
   task automatic do_pulse(input int h, input int l);
      hold_pin(1'b1, h);
      hold_pin(1'b0, l);
      exp_q.push_back({1'b0, CNT_W'(h), CNT_W'(h + l)});
   endtask

   // Closing rise: long enough for the edge to cross the synchronizer.
   task automatic final_rise();
      hold_pin(1'b1, 6);
   endtask

   task automatic pop_one();
      pop = 1'b1;
      step(1);
      pop = 1'b0;
   endtask

   task automatic drain(input int n, input string tag);
      logic [REC_W-1:0] r;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_nonempty"}, 64'(empty), 64'(1'b0));
         if (exp_q.size() > 0) r = exp_q.pop_front();
         else r = 'x;
         chk({tag, "_rec"}, 64'({rd_sat, rd_high, rd_period}), 64'(r));
         pop_one();
      end
      chk({tag, "_empty"}, 64'(empty), 64'(1'b1));
   endtask

   task automatic restart();
      enable = 1'b0;
      hold_pin(1'b0, 6);
      enable = 1'b1;
      step(3);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed / random sequence ----------------
   initial begin
      int n;
      reset = 1'b1;
      pin = 1'b0; enable = 1'b0; pop = 1'b0; clr_ovf = 1'b0;
      pin_s = 1'b0; enable_s = 1'b0; pop_s = 1'b0; clr_ovf_s = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      step(1);

      // reset values
      chk("rst_empty", 64'(empty), 64'(1'b1));
      chk("rst_full", 64'(full), 64'(1'b0));
      chk("rst_ovf", 64'(overflow), 64'(1'b0));
      chk("rst_rd", 64'({rd_sat, rd_high, rd_period}), 64'(0));
      chk("rst_state", 64'(fsm_state), 64'(0));
      chk("rst_empty_s", 64'(empty_s), 64'(1'b1));

      enable = 1'b1;
      step(3);
      chk("arm_state", 64'(fsm_state), 64'(1));

      // 5 high / 15 low, three periods
      hold_pin(1'b0, 4);
      for (int i = 0; i < 3; i++) do_pulse(5, 15);
      final_rise();
      drain(3, "t1");
      restart();

      // duty sweep, fills the FIFO exactly
      do_pulse(1, 1);
      do_pulse(19, 1);
      do_pulse(1, 1);
      do_pulse(19, 1);
      final_rise();
      chk("t2_full", 64'(full), 64'(1'b1));
      chk("t2_ovf", 64'(overflow), 64'(1'b0));
      drain(4, "t2");
      restart();

      // random bursts
      for (int b = 0; b < 6; b++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) do_pulse($urandom_range(1, 12), $urandom_range(1, 12));
         final_rise();
         drain(n, "rand");
         restart();
      end

      // saturation with 4-bit counters: stuck low after rise+fall
      enable_s = 1'b1;
      step(3);
      pin_s = 1'b1;
      step(3);
      pin_s = 1'b0;
      step(30);
      chk("sat_lo_nonempty", 64'(empty_s), 64'(1'b0));
      chk("sat_lo_rec", 64'({rd_sat_s, rd_high_s, rd_period_s}), 64'({1'b1, 4'd3, 4'd15}));
      chk("sat_lo_state", 64'(fsm_state_s), 64'(1));
      pop_s = 1'b1;
      step(1);
      pop_s = 1'b0;
      chk("sat_lo_one", 64'(empty_s), 64'(1'b1));
      // stuck high
      pin_s = 1'b1;
      step(30);
      chk("sat_hi_nonempty", 64'(empty_s), 64'(1'b0));
      chk("sat_hi_rec", 64'({rd_sat_s, rd_high_s, rd_period_s}), 64'({1'b1, 4'd15, 4'd15}));
      pop_s = 1'b1;
      step(1);
      pop_s = 1'b0;
      chk("sat_hi_one", 64'(empty_s), 64'(1'b1));
      chk("sat_hi_state", 64'(fsm_state_s), 64'(1));
      enable_s = 1'b0;
      pin_s = 1'b0;

      // overflow: six periods with no pop, first four kept
      for (int i = 0; i < 6; i++) do_pulse($urandom_range(2, 8), $urandom_range(2, 8));
      final_rise();
      chk("t4_full", 64'(full), 64'(1'b1));
      chk("t4_ovf", 64'(overflow), 64'(1'b1));
      drain(4, "t4");
      exp_q.delete();
      chk("t4_ovf_sticky", 64'(overflow), 64'(1'b1));
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("t4_ovf_clr", 64'(overflow), 64'(1'b0));
      restart();

      // full FIFO, pop on the same cycle as the push
      for (int i = 0; i < 5; i++) do_pulse($urandom_range(2, 8), $urandom_range(2, 8));
      pin = 1'b1;
      step(2);
      chk("t5_full_pre", 64'(full), 64'(1'b1));
      pop = 1'b1;
      step(1);
      pop = 1'b0;
      chk("t5_full", 64'(full), 64'(1'b1));
      chk("t5_ovf", 64'(overflow), 64'(1'b0));
      chk("t5_head", 64'({rd_sat, rd_high, rd_period}), 64'(exp_q[1]));
      void'(exp_q.pop_front());
      drain(4, "t5");
      restart();

      // enable dropped mid-HIGH: no partial record
      pin = 1'b1;
      step(6);
      chk("t6_high", 64'(fsm_state), 64'(2));
      enable = 1'b0;
      step(2);
      chk("t6_idle", 64'(fsm_state), 64'(0));
      hold_pin(1'b0, 6);
      chk("t6_no_partial", 64'(empty), 64'(1'b1));
      enable = 1'b1;
      step(3);
      do_pulse(7, 9);
      do_pulse(3, 4);
      final_rise();
      drain(2, "t6a");
      restart();

      // reset mid-period with a full FIFO and overflow set
      for (int i = 0; i < 5; i++) do_pulse(3, 3);
      hold_pin(1'b1, 5);
      chk("t6b_full", 64'(full), 64'(1'b1));
      chk("t6b_ovf", 64'(overflow), 64'(1'b1));
      reset = 1'b1;
      #1;
      chk("t6b_empty", 64'(empty), 64'(1'b1));
      chk("t6b_full0", 64'(full), 64'(1'b0));
      chk("t6b_ovf0", 64'(overflow), 64'(1'b0));
      chk("t6b_rd", 64'({rd_sat, rd_high, rd_period}), 64'(0));
      chk("t6b_state", 64'(fsm_state), 64'(0));
      exp_q.delete();
      pin = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(4);

      // measurement resumes after reset
      do_pulse(6, 2);
      do_pulse(2, 6);
      final_rise();
      drain(2, "post");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
